// File: rtl/cavenger_input_pkg.sv
// Shared scancodes, joystick bit positions and coin FSM types for the
// Cosmic Avenger input-conditioning stage.
package cavenger_input_pkg;

    localparam logic [7:0] SC_P1_UP     = 8'h75;
    localparam logic [7:0] SC_P1_DOWN   = 8'h72;
    localparam logic [7:0] SC_P1_LEFT   = 8'h6B;
    localparam logic [7:0] SC_P1_RIGHT  = 8'h74;
    localparam logic [7:0] SC_P1_FIRE   = 8'h14;
    localparam logic [7:0] SC_P1_BOMB   = 8'h29;
    localparam logic [7:0] SC_P2_UP     = 8'h2D;
    localparam logic [7:0] SC_P2_DOWN   = 8'h2B;
    localparam logic [7:0] SC_P2_LEFT   = 8'h23;
    localparam logic [7:0] SC_P2_RIGHT  = 8'h34;
    localparam logic [7:0] SC_P2_FIRE   = 8'h1C;
    localparam logic [7:0] SC_P2_BOMB   = 8'h1B;
    localparam logic [7:0] SC_START1_A  = 8'h05;
    localparam logic [7:0] SC_START1_B  = 8'h16;
    localparam logic [7:0] SC_START2_A  = 8'h06;
    localparam logic [7:0] SC_START2_B  = 8'h1E;
    localparam logic [7:0] SC_COIN_A    = 8'h2E;
    localparam logic [7:0] SC_COIN_B    = 8'h36;

    localparam int JB_RIGHT  = 0;
    localparam int JB_LEFT   = 1;
    localparam int JB_DOWN   = 2;
    localparam int JB_UP     = 3;
    localparam int JB_FIRE   = 4;
    localparam int JB_BOMB   = 5;
    localparam int JB_START1 = 6;
    localparam int JB_START2 = 7;

    typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} coin_state_t;

    // Keyboard-held state; [0] player 1, [1] player 2 for the paired fields.
    typedef struct packed {
        logic [1:0] up;
        logic [1:0] down;
        logic [1:0] left;
        logic [1:0] right;
        logic [1:0] fire;
        logic [1:0] bomb;
        logic       start1;
        logic       start2;
        logic       coin;
    } keys_t;

    // Menu lives setting to the core's DIP encoding (3/4/5/2 lives).
    function automatic logic [1:0] lives_code(input logic [1:0] lives);
        case (lives)
            2'd0:    lives_code = 2'b00;
            2'd1:    lives_code = 2'b11;
            2'd2:    lives_code = 2'b10;
            default: lives_code = 2'b01;
        endcase
    endfunction

endpackage

// File: rtl/cavenger_coin_pulse.sv
// Coin shaper: a fresh request edge in IDLE yields a COIN_PULSE-cycle active
// window followed by COIN_HOLDOFF dead cycles; edges seen while busy are dropped.
module cavenger_coin_pulse
    import cavenger_input_pkg::*;
#(
    parameter int COIN_PULSE   = 2_000_000,
    parameter int COIN_HOLDOFF = 2_000_000
) (
    input  logic clk_sys,
    input  logic RESET,
    input  logic coin_req_i,
    output logic coin_act_o
);
    localparam int MAXC = (COIN_PULSE > COIN_HOLDOFF) ? COIN_PULSE : COIN_HOLDOFF;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    coin_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q;
    logic          req_rise;

    assign req_rise = coin_req_i & ~req_q;

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= coin_req_i;
        end
    end

    // Counter only loads or decrements from non-zero, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_rise) begin
                    state_d = PULSE;
                    cnt_d   = CW'(COIN_PULSE - 1);
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = HOLDOFF;
                    cnt_d   = CW'(COIN_HOLDOFF - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLDOFF: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        coin_act_o = (state_q == PULSE);
    end

endmodule

// File: rtl/cavenger_input.sv
// Input conditioning ahead of the ladybug core: PS/2 key decode, joystick merge,
// DIP byte and coin shaping. Define CAVENGER_COIN_STRETCH_EN for fixed-length coin pulses.
module cavenger_input
    import cavenger_input_pkg::*;
#(
    parameter int COIN_PULSE   = 2_000_000,
    parameter int COIN_HOLDOFF = 2_000_000
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic [1:0]  difficulty,
    input  logic [1:0]  lives,
    input  logic        cabinet,
    output logic [1:0]  but_coin_s,
    output logic [1:0]  but_fire_s,
    output logic [1:0]  but_bomb_s,
    output logic [1:0]  but_tilt_s,
    output logic [1:0]  but_select_s,
    output logic [1:0]  but_up_s,
    output logic [1:0]  but_down_s,
    output logic [1:0]  but_left_s,
    output logic [1:0]  but_right_s,
    output logic [7:0]  dip_block_1_s
);
    logic       ev_q;
    keys_t      keys_q, keys_d;
    logic       ps2_ev;
    logic       pressed;
    logic       ext;
    logic [7:0] code;

    logic [1:0] up_m, down_m, left_m, right_m, fire_m, bomb_m, select_m;
    logic       coin_req;
    logic       coin_n;

    logic [1:0] up_q, down_q, left_q, right_q, fire_q, bomb_q, select_q;
    logic       coin_q;
    logic [7:0] dip_q;

    logic       unused_joy;

    assign ps2_ev  = ps2_key[10] ^ ev_q;
    assign pressed = ps2_key[9];
    assign ext     = ps2_key[8];
    assign code    = ps2_key[7:0];

    // Arrow keys are accepted with or without the E0 prefix; everything else must be plain.
    always_comb begin
        keys_d = keys_q;
        if (ps2_ev) begin
            case (code)
                SC_P1_UP:    keys_d.up[0]    = pressed;
                SC_P1_DOWN:  keys_d.down[0]  = pressed;
                SC_P1_LEFT:  keys_d.left[0]  = pressed;
                SC_P1_RIGHT: keys_d.right[0] = pressed;
                default: ;
            endcase
            if (!ext) begin
                case (code)
                    SC_P1_FIRE:               keys_d.fire[0]  = pressed;
                    SC_P1_BOMB:               keys_d.bomb[0]  = pressed;
                    SC_P2_UP:                 keys_d.up[1]    = pressed;
                    SC_P2_DOWN:               keys_d.down[1]  = pressed;
                    SC_P2_LEFT:               keys_d.left[1]  = pressed;
                    SC_P2_RIGHT:              keys_d.right[1] = pressed;
                    SC_P2_FIRE:               keys_d.fire[1]  = pressed;
                    SC_P2_BOMB:               keys_d.bomb[1]  = pressed;
                    SC_START1_A, SC_START1_B: keys_d.start1   = pressed;
                    SC_START2_A, SC_START2_B: keys_d.start2   = pressed;
                    SC_COIN_A, SC_COIN_B:     keys_d.coin     = pressed;
                    default: ;
                endcase
            end
        end
    end

    assign up_m     = keys_q.up    | {joystick_1[JB_UP],    joystick_0[JB_UP]};
    assign down_m   = keys_q.down  | {joystick_1[JB_DOWN],  joystick_0[JB_DOWN]};
    assign left_m   = keys_q.left  | {joystick_1[JB_LEFT],  joystick_0[JB_LEFT]};
    assign right_m  = keys_q.right | {joystick_1[JB_RIGHT], joystick_0[JB_RIGHT]};
    assign fire_m   = keys_q.fire  | {joystick_1[JB_FIRE],  joystick_0[JB_FIRE]};
    assign bomb_m   = keys_q.bomb  | {joystick_1[JB_BOMB],  joystick_0[JB_BOMB]};

    // Either stick's start button drives the shared start inputs.
    assign select_m[0] = keys_q.start1 | joystick_0[JB_START1] | joystick_1[JB_START1];
    assign select_m[1] = keys_q.start2 | joystick_0[JB_START2] | joystick_1[JB_START2];
    assign coin_req    = keys_q.coin | (|select_m);

    assign unused_joy = ^{joystick_0[15:8], joystick_1[15:8]};

`ifdef CAVENGER_COIN_STRETCH_EN
    logic coin_act;

    cavenger_coin_pulse #(
        .COIN_PULSE   (COIN_PULSE),
        .COIN_HOLDOFF (COIN_HOLDOFF)
    ) u_coin (
        .clk_sys    (clk_sys),
        .RESET      (RESET),
        .coin_req_i (coin_req),
        .coin_act_o (coin_act)
    );

    assign coin_n = ~coin_act;
`else
    logic unused_params;

    assign unused_params = ^{COIN_PULSE, COIN_HOLDOFF};
    assign coin_n        = ~coin_req;
`endif

    always_ff @(posedge clk_sys) begin
        ev_q <= ps2_key[10];
        if (RESET) begin
            keys_q   <= '0;
            up_q     <= 2'b11;
            down_q   <= 2'b11;
            left_q   <= 2'b11;
            right_q  <= 2'b11;
            fire_q   <= 2'b11;
            bomb_q   <= 2'b11;
            select_q <= 2'b11;
            coin_q   <= 1'b1;
            dip_q    <= 8'hFF;
        end else begin
            keys_q   <= keys_d;
            up_q     <= ~up_m;
            down_q   <= ~down_m;
            left_q   <= ~left_m;
            right_q  <= ~right_m;
            fire_q   <= ~fire_m;
            bomb_q   <= ~bomb_m;
            select_q <= ~select_m;
            coin_q   <= coin_n;
            dip_q    <= {~lives_code(lives), 2'b11, cabinet, 1'b0, ~difficulty};
        end
    end

    assign but_coin_s    = {1'b1, coin_q};
    assign but_fire_s    = fire_q;
    assign but_bomb_s    = bomb_q;
    assign but_tilt_s    = 2'b11;
    assign but_select_s  = select_q;
    assign but_up_s      = up_q;
    assign but_down_s    = down_q;
    assign but_left_s    = left_q;
    assign but_right_s   = right_q;
    assign dip_block_1_s = dip_q;

endmodule

// File: tb/tb_cavenger_input.sv
// Bench for cavenger_input: directed scenarios plus randomized PS/2/joystick
// traffic against a behavioural reference of key state, merge, DIP and coin timing.
module tb_cavenger_input;
    localparam int P = 4;
    localparam int H = 3;

    logic        clk_sys = 1'b0;
    logic        RESET;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0, joystick_1;
    logic [1:0]  difficulty, lives;
    logic        cabinet;
    logic [1:0]  but_coin_s, but_fire_s, but_bomb_s, but_tilt_s, but_select_s;
    logic [1:0]  but_up_s, but_down_s, but_left_s, but_right_s;
    logic [7:0]  dip_block_1_s;

    always #5 clk_sys = ~clk_sys;

    cavenger_input #(.COIN_PULSE(P), .COIN_HOLDOFF(H)) dut (
        .clk_sys       (clk_sys),
        .RESET         (RESET),
        .ps2_key       (ps2_key),
        .joystick_0    (joystick_0),
        .joystick_1    (joystick_1),
        .difficulty    (difficulty),
        .lives         (lives),
        .cabinet       (cabinet),
        .but_coin_s    (but_coin_s),
        .but_fire_s    (but_fire_s),
        .but_bomb_s    (but_bomb_s),
        .but_tilt_s    (but_tilt_s),
        .but_select_s  (but_select_s),
        .but_up_s      (but_up_s),
        .but_down_s    (but_down_s),
        .but_left_s    (but_left_s),
        .but_right_s   (but_right_s),
        .dip_block_1_s (dip_block_1_s)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: which keys are held, a pending PS/2 event, coin pulse bookkeeping.
    logic [1:0]  m_up, m_dn, m_lt, m_rt, m_fi, m_bo;
    logic        m_s1, m_s2, m_coin;
    logic        pend;
    logic [7:0]  pend_code;
    logic        pend_ext, pend_pr;
    logic        m_prev_req;
    int          m_start, m_ready;
    logic [25:0] m_out;

    logic [7:0] codes [0:23] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h29,
                                 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B,
                                 8'h05, 8'h16, 8'h06, 8'h1E, 8'h2E, 8'h36,
                                 8'h00, 8'h5A, 8'h12, 8'h76, 8'hF0, 8'h15};

    function automatic logic [25:0] obs_vec();
        return {but_coin_s, but_fire_s, but_bomb_s, but_tilt_s, but_select_s,
                but_up_s, but_down_s, but_left_s, but_right_s, dip_block_1_s};
    endfunction

    function automatic logic any_req();
        return m_coin | m_s1 | m_s2 | joystick_0[6] | joystick_0[7] | joystick_1[6] | joystick_1[7];
    endfunction

    function automatic logic [1:0] lives_inv(input logic [1:0] l);
        case (l)
            2'd0:    return 2'b11;   // 3 lives
            2'd1:    return 2'b00;   // 4 lives
            2'd2:    return 2'b01;   // 5 lives
            default: return 2'b10;   // 2 lives
        endcase
    endfunction

    // Expected registered outputs produced by edge number e.
    function automatic logic [25:0] compute_out(input int e);
        logic c0;
        logic [1:0] sel;
`ifdef CAVENGER_COIN_STRETCH_EN
        c0 = !((e >= m_start + 1) && (e <= m_start + P));
`else
        c0 = ~any_req();
`endif
        sel = {m_s2 | joystick_0[7] | joystick_1[7], m_s1 | joystick_0[6] | joystick_1[6]};
        return {1'b1, c0,
                ~(m_fi | {joystick_1[4], joystick_0[4]}),
                ~(m_bo | {joystick_1[5], joystick_0[5]}),
                2'b11,
                ~sel,
                ~(m_up | {joystick_1[3], joystick_0[3]}),
                ~(m_dn | {joystick_1[2], joystick_0[2]}),
                ~(m_lt | {joystick_1[1], joystick_0[1]}),
                ~(m_rt | {joystick_1[0], joystick_0[0]}),
                lives_inv(lives), 2'b11, cabinet, 1'b0, ~difficulty};
    endfunction

    task automatic model_apply(input logic [7:0] c, input logic ext, input logic pr);
        bit arrow;
        arrow = (c == 8'h75) || (c == 8'h72) || (c == 8'h6B) || (c == 8'h74);
        if (ext && !arrow) return;
        case (c)
            8'h75: m_up[0] = pr;
            8'h72: m_dn[0] = pr;
            8'h6B: m_lt[0] = pr;
            8'h74: m_rt[0] = pr;
            8'h14: m_fi[0] = pr;
            8'h29: m_bo[0] = pr;
            8'h2D: m_up[1] = pr;
            8'h2B: m_dn[1] = pr;
            8'h23: m_lt[1] = pr;
            8'h34: m_rt[1] = pr;
            8'h1C: m_fi[1] = pr;
            8'h1B: m_bo[1] = pr;
            8'h05, 8'h16: m_s1 = pr;
            8'h06, 8'h1E: m_s2 = pr;
            8'h2E, 8'h36: m_coin = pr;
            default: ;
        endcase
    endtask

    // Advance one clock edge, updating the model with the inputs present at that edge.
    task automatic step();
        logic [25:0] nxt;
        logic req;
        if (RESET) begin
            nxt = {18'h3FFFF, 8'hFF};
            {m_up, m_dn, m_lt, m_rt, m_fi, m_bo} = '0;
            {m_s1, m_s2, m_coin} = '0;
            pend = 1'b0;
            m_prev_req = 1'b0;
            m_start = -100;
            m_ready = 0;
        end else begin
            nxt = compute_out(cyc);
            req = any_req();
            if (req && !m_prev_req && cyc >= m_ready) begin
                m_start = cyc;
                m_ready = cyc + P + H + 1;
            end
            m_prev_req = req;
            if (pend) model_apply(pend_code, pend_ext, pend_pr);
            pend = 1'b0;
        end
        @(posedge clk_sys);
        #1;
        m_out = nxt;
        cyc++;
    endtask

    task automatic ps2_ev(input logic [7:0] c, input logic ext, input logic pr);
        ps2_key   = {~ps2_key[10], pr, ext, c};
        pend      = 1'b1;
        pend_code = c;
        pend_ext  = ext;
        pend_pr   = pr;
        step();
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        ps2_key = 11'h400;
        joystick_0 = '0;
        joystick_1 = '0;
        difficulty = 2'd1;
        lives = 2'd0;
        cabinet = 1'b0;
        step();
        step();
        n_checks++;
        if (obs_vec() !== m_out) $display("FAIL reset_outputs: got %h expected %h", obs_vec(), m_out);
        else n_pass++;
        n_checks++;
        if (dip_block_1_s !== 8'hFF) $display("FAIL reset_dip: got %h expected ff", dip_block_1_s);
        else n_pass++;
        RESET = 1'b0;
        step();
        n_checks++;
        if (dip_block_1_s !== 8'hF2) $display("FAIL reset_dip_after: got %h expected f2", dip_block_1_s);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (obs_vec() !== m_out) $display("FAIL reset_no_key: got %h expected %h", obs_vec(), m_out);
            else n_pass++;
        end
    endtask

    task automatic test_ps2_up();
        ps2_ev(8'h75, 1'b1, 1'b1);
        n_checks++;
        if (but_up_s !== 2'b11) $display("FAIL up_latency1: got %b expected 11", but_up_s);
        else n_pass++;
        step();
        n_checks++;
        if (but_up_s !== 2'b10) $display("FAIL up_press: got %b expected 10", but_up_s);
        else n_pass++;
        ps2_ev(8'h75, 1'b1, 1'b0);
        step();
        n_checks++;
        if (obs_vec() !== m_out || but_up_s !== 2'b11)
            $display("FAIL up_release: got %h expected %h", obs_vec(), m_out);
        else n_pass++;
    endtask

    task automatic test_fire();
        joystick_1[4] = 1'b1;
        step();
        n_checks++;
        if (but_fire_s !== 2'b01) $display("FAIL fire_joy1: got %b expected 01", but_fire_s);
        else n_pass++;
        joystick_1[4] = 1'b0;
        ps2_ev(8'h1C, 1'b0, 1'b1);
        step();
        n_checks++;
        if (but_fire_s !== 2'b01) $display("FAIL fire_key2: got %b expected 01", but_fire_s);
        else n_pass++;
        ps2_ev(8'h1C, 1'b0, 1'b0);
        joystick_0[4] = 1'b1;
        step();
        n_checks++;
        if (but_fire_s !== 2'b10 || obs_vec() !== m_out)
            $display("FAIL fire_joy0_only_p1: got %h expected %h", obs_vec(), m_out);
        else n_pass++;
        joystick_0[4] = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        ps2_ev(8'h6B, 1'b1, 1'b1);
        ps2_ev(8'h74, 1'b0, 1'b1);
        ps2_ev(8'h14, 1'b1, 1'b1);  // fire with E0 prefix must be ignored
        step();
        n_checks++;
        if (but_left_s !== 2'b10 || but_right_s !== 2'b10 || but_fire_s !== 2'b11)
            $display("FAIL b2b_press: got l=%b r=%b f=%b expected l=10 r=10 f=11",
                     but_left_s, but_right_s, but_fire_s);
        else n_pass++;
        ps2_ev(8'h6B, 1'b0, 1'b0);
        ps2_ev(8'h74, 1'b1, 1'b0);
        step();
        n_checks++;
        if (obs_vec() !== m_out || but_left_s !== 2'b11 || but_right_s !== 2'b11)
            $display("FAIL b2b_release: got %h expected %h", obs_vec(), m_out);
        else n_pass++;
    endtask

`ifdef CAVENGER_COIN_STRETCH_EN
    task automatic test_coin_stretch();
        int lows;
        for (int i = 0; i < 10; i++) step();
        lows = 0;
        ps2_ev(8'h2E, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step();
            if (but_coin_s[0] === 1'b0) lows++;
            n_checks++;
            if (obs_vec() !== m_out) $display("FAIL coin_held: got %h expected %h", obs_vec(), m_out);
            else n_pass++;
        end
        n_checks++;
        if (lows != P) $display("FAIL coin_held_len: got %0d expected %0d", lows, P);
        else n_pass++;
        ps2_ev(8'h2E, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step();

        // Edges at +0 (pulse), +5 (inside holdoff, dropped), +9 (accepted).
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            joystick_0[6] = (i < 3) || (i == 5) || (i >= 9);
            step();
            if (but_coin_s[0] === 1'b0) lows++;
            n_checks++;
            if (obs_vec() !== m_out) $display("FAIL coin_holdoff: got %h expected %h", obs_vec(), m_out);
            else n_pass++;
        end
        n_checks++;
        if (lows != 2 * P) $display("FAIL coin_holdoff_len: got %0d expected %0d", lows, 2 * P);
        else n_pass++;
        joystick_0[6] = 1'b0;
        for (int i = 0; i < 10; i++) step();

        joystick_0[6] = 1'b1;
        step();
        step();
        step();
        n_checks++;
        if (but_coin_s[0] !== 1'b0) $display("FAIL coin_midpulse: got %b expected 0", but_coin_s[0]);
        else n_pass++;
        RESET = 1'b1;
        step();
        n_checks++;
        if (but_coin_s[0] !== 1'b1 || obs_vec() !== m_out)
            $display("FAIL coin_reset: got %h expected %h", obs_vec(), m_out);
        else n_pass++;
        RESET = 1'b0;
        joystick_0[6] = 1'b0;
        step();
        joystick_0[6] = 1'b1;
        step();
        step();
        n_checks++;
        if (but_coin_s[0] !== 1'b0 || obs_vec() !== m_out)
            $display("FAIL coin_after_reset: got %h expected %h", obs_vec(), m_out);
        else n_pass++;
        joystick_0[6] = 1'b0;
        for (int i = 0; i < 10; i++) step();
    endtask
`else
    task automatic test_coin_level();
        int lows;
        lows = 0;
        joystick_0[6] = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i == 10) joystick_0[6] = 1'b0;
            step();
            if (but_coin_s[0] === 1'b0) lows++;
            n_checks++;
            if (obs_vec() !== m_out || but_coin_s[0] !== (i >= 10))
                $display("FAIL coin_level: got %h expected %h", obs_vec(), m_out);
            else n_pass++;
        end
        n_checks++;
        if (lows != 10) $display("FAIL coin_level_len: got %0d expected 10", lows);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                joystick_0 = (16'($urandom) & 16'hFF3F) | (($urandom_range(0, 5) == 0) ? 16'h0040 : 16'h0);
                joystick_1 = (16'($urandom) & 16'hFF3F) | (($urandom_range(0, 7) == 0) ? 16'h0080 : 16'h0);
            end
            if ($urandom_range(0, 15) == 0) begin
                difficulty = 2'($urandom);
                lives = 2'($urandom);
                cabinet = 1'($urandom);
            end
            if ($urandom_range(0, 2) == 0)
                ps2_ev(codes[$urandom_range(0, 23)], ($urandom_range(0, 3) == 0), 1'($urandom));
            else
                step();
            n_checks++;
            if (obs_vec() !== m_out) $display("FAIL random_cyc%0d: got %h expected %h", i, obs_vec(), m_out);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_ps2_up();
        test_fire();
        test_back_to_back();
`ifdef CAVENGER_COIN_STRETCH_EN
        test_coin_stretch();
`else
        test_coin_level();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
